data_ram_resp: RTL and testbench
================================

# data_ram_resp

Data-memory responder on the far end of the core's data bus (`ram_ce`/`ram_we`/`ram_sel`/`ram_addr`/`ram_data`) at the SoC top level. It holds a word-organised RAM, commits byte-lane writes on the clock edge, and returns read data combinationally in the same cycle, which the core's MEM stage requires. After every reset a clear engine zeroes the whole array before the responder accepts traffic. Out-of-range and illegal accesses are flagged.

## Interface
- `DEPTH_LOG2`, 10, log2 of the number of 32-bit words (default 1024 words = 4 KiB).
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `ce`  in  1  access enable from the core (`ram_ce_o`).
- `we`  in  1  1 = write, 0 = read (`ram_we_o`).
- `sel`  in  4  byte lane enables (`ram_sel_o`); `sel[3]` is `data[31:24]` (big-endian lanes).
- `addr`  in  32  byte address (`ram_addr_o`); word index is `addr[DEPTH_LOG2+1:2]`.
- `data_i`  in  32  write data (`ram_data_o`).
- `data_o`  out  32  read data to the core (`ram_data_i`).
- `ready`  out  1  1 once the clear sweep has completed.
- `oor_err`  out  1  sticky: an access had `addr[31:DEPTH_LOG2+2]` ≠ 0.
- `sel_err`  out  1  sticky: a write had `sel == 4'b0000`.
- `wr_count`  out  16  number of committed writes, saturating at 16'hFFFF.

## Operation
- FSM has two states: `INIT` and `RUN`.
- **Reset (`rst` = 0, asynchronous)**
  - state becomes `INIT`, clear counter = 0.
  - `ready`, `oor_err`, `sel_err` = 0; `wr_count` = 0.
  - `data_o` = 0 combinationally.
  - Array contents are undefined until the sweep runs.
- **INIT**
  - Each edge writes 32'h0 to `mem[clr_cnt]`, then increments `clr_cnt`.
  - When `clr_cnt` = 2^DEPTH_LOG2 − 1, that word is cleared and the state moves to `RUN` on the same edge.
  - All bus accesses in `INIT` are ignored: no write, `data_o` = 0, no error flags, no count.
- **RUN, write** (`ce` & `we`, in range): on the edge, for each lane `i` with `sel[i]` = 1, `mem[idx][8i+7:8i]` ← `data_i[8i+7:8i]`. Lanes with `sel[i]` = 0 are unchanged.
- **`wr_count`** increments by one per committed write with `sel` ≠ 0 and holds at 16'hFFFF.
- **RUN, read** (`ce` & !`we`, in range): `data_o` = `mem[idx]` combinationally, full word. The core extracts the byte or halfword; `sel` is ignored for reads.
- **`data_o`** = 0 whenever `ce` = 0, `we` = 1, out of range, or state ≠ `RUN`.
- **Out of range** (`ce` = 1 and upper address bits ≠ 0): the write is dropped, a read returns 0, and `oor_err` is set on the edge.
- **`addr[1:0]`** is ignored; the core is responsible for alignment.
- **Write with `sel` = 0**: no array change, no count, `sel_err` is set on the edge.
- **Error flags** clear only on reset.

## Timing
- Read latency is 0 cycles (combinational from `addr`/`ce`/`we` and array contents).
- Write latency is 1 edge. A read of the same word in the cycle after the write returns the new data.
- Read-during-write to the same word in the same cycle is not possible: `we` selects one or the other.
- `ready` rises exactly 2^DEPTH_LOG2 rising edges after `rst` deasserts (first edge with `rst` = 1 counts as edge 1).
- Reset asserted mid-sweep or mid-RUN takes effect immediately. After release the sweep restarts from word 0 and takes the full 2^DEPTH_LOG2 edges.
- Accesses are single-cycle: back-to-back writes and reads on consecutive cycles are fully supported, with no stall or backpressure output.
- Software must not issue accesses before `ready` = 1. The top level holds the core in reset until then.

## Test plan
- **Clear sweep.** `DEPTH_LOG2`=4, hold `rst`=0 for 3 cycles, release. Required: `ready`=0 for edges 1–15, `ready`=1 after edge 16. Reads of words 0–15 then return 32'h0.
- **Byte-lane write.** Write 32'hFFFFFFFF to addr 0x8 with `sel`=1111, then 32'h12345678 with `sel`=0101. A read of 0x8 returns 32'hFF34FF78 and `wr_count`=2.
- **Ignored during INIT, then visible in RUN.** Write 32'hDEADBEEF to 0x4 while `ready`=0: a read after `ready` returns 0. Repeat the write in RUN: the next-cycle read returns 32'hDEADBEEF. `data_o` = 0 whenever `ce`=0.
- **Out of range.** `DEPTH_LOG2`=4, write 32'hA5A5A5A5 to addr 0x40. `oor_err`=1, words 0–15 are unchanged (addr 0x0 still 0), a read of 0x40 returns 0, and `wr_count` does not increment.
- **Empty-select write.** Write with `sel`=0000 to 0x0: `sel_err`=1, word 0 unchanged, `wr_count` unchanged. Flags stay set across further valid accesses.
- **Reset mid-operation.** Write 32'h11111111 to 0xC, then pulse `rst` low for a half cycle. Required: `ready`, `oor_err`, `sel_err`, `wr_count` drop to 0 immediately. A new 16-edge sweep follows, and 0xC then reads 32'h0.

Source files
------------

// File: rtl/data_ram_resp_if.sv
// ----------------------------------------------------------------------------
// data_ram_resp_if
// Data-bus bundle between the core's MEM stage and the data RAM responder.
//   ce      core -> ram   access enable
//   we      core -> ram   1 = write, 0 = read
//   sel     core -> ram   byte lane enables, sel[3] is data[31:24]
//   addr    core -> ram   byte address
//   data_i  core -> ram   write data
//   data_o  ram  -> core  combinational read data
// ----------------------------------------------------------------------------
interface data_ram_resp_if;
    logic        ce;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] addr;
    logic [31:0] data_i;
    logic [31:0] data_o;

    modport master (
        output ce, we, sel, addr, data_i,
        input  data_o
    );

    modport slave (
        input  ce, we, sel, addr, data_i,
        output data_o
    );
endinterface

// File: rtl/data_ram_resp.sv
// ----------------------------------------------------------------------------
// data_ram_resp
// Word-organised data RAM on the far end of the core's data bus. Writes commit
// byte lanes on the rising edge; reads return the full word combinationally in
// the same cycle. After every reset a sweep zeroes the array, one word per
// edge, before any bus traffic is honoured.
//
// Ports
//   clk       clock, rising edge
//   rst       asynchronous active-low reset
//   bus       data bus (slave side), see data_ram_resp_if
//   ready     1 once the clear sweep has completed
//   oor_err   sticky: an access had address bits above the array set
//   sel_err   sticky: a write arrived with no byte lane enabled
//   wr_count  committed writes, saturating at 16'hFFFF
// ----------------------------------------------------------------------------
module data_ram_resp #(
    parameter int DEPTH_LOG2 = 10
) (
    input  logic                clk,
    input  logic                rst,
    data_ram_resp_if.slave      bus,
    output logic                ready,
    output logic                oor_err,
    output logic                sel_err,
    output logic [15:0]         wr_count
);

    localparam int                    DEPTH    = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2-1:0] CLR_LAST = DEPTH_LOG2'(DEPTH - 1);

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_e;

    state_e                  state_q, state_d;
    logic [DEPTH_LOG2-1:0]   clr_cnt_q, clr_cnt_d;
    logic                    oor_err_q, oor_err_d;
    logic                    sel_err_q, sel_err_d;
    logic [15:0]             wr_count_q, wr_count_d;

    logic [31:0]             mem [DEPTH];

    logic                    mem_we;
    logic [DEPTH_LOG2-1:0]   mem_idx;
    logic [3:0]              mem_be;
    logic [31:0]             mem_wdata;

    logic [DEPTH_LOG2-1:0]   word_idx;
    logic                    in_range;
    logic                    unused_addr_lo;

    assign word_idx       = bus.addr[DEPTH_LOG2+1:2];
    assign in_range       = (bus.addr[31:DEPTH_LOG2+2] == '0);
    // Byte offset is the core's concern; the responder works in whole words.
    assign unused_addr_lo = ^bus.addr[1:0];

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbours, independent of block order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= INIT;
            clr_cnt_q  <= '0;
            oor_err_q  <= 1'b0;
            sel_err_q  <= 1'b0;
            wr_count_q <= '0;
        end else begin
            state_q    <= state_d;
            clr_cnt_q  <= clr_cnt_d;
            oor_err_q  <= oor_err_d;
            sel_err_q  <= sel_err_d;
            wr_count_q <= wr_count_d;
        end
    end

    // NOTE: the array has no reset; the clear sweep after reset zeroes it,
    // which keeps it mappable onto plain RAM macros.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (mem_be[i]) begin
                    mem[mem_idx][8*i +: 8] <= mem_wdata[8*i +: 8];
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Next-state logic: sweep progress, bus write decode, sticky flags
    // ------------------------------------------------------------------------
    always_comb begin
        // NOTE: every comb output gets a default first so no path leaves it
        // unassigned, which would otherwise infer a latch.
        state_d    = state_q;
        clr_cnt_d  = clr_cnt_q;
        oor_err_d  = oor_err_q;
        sel_err_d  = sel_err_q;
        wr_count_d = wr_count_q;
        mem_we     = 1'b0;
        mem_idx    = word_idx;
        mem_be     = bus.sel;
        mem_wdata  = bus.data_i;

        unique case (state_q)
            INIT: begin
                // Sweep owns the write port; bus traffic is ignored entirely.
                mem_we    = 1'b1;
                mem_idx   = clr_cnt_q;
                mem_be    = 4'hF;
                mem_wdata = '0;
                clr_cnt_d = clr_cnt_q + 1'b1;
                if (clr_cnt_q == CLR_LAST) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (bus.ce) begin
                    if (!in_range) begin
                        oor_err_d = 1'b1;
                    end
                    if (bus.we) begin
                        if (bus.sel == 4'b0000) begin
                            sel_err_d = 1'b1;
                        end else if (in_range) begin
                            mem_we = 1'b1;
                            if (wr_count_q != 16'hFFFF) begin
                                wr_count_d = wr_count_q + 16'd1;
                            end
                        end
                    end
                end
            end
            default: state_d = INIT;
        endcase
    end

    // ------------------------------------------------------------------------
    // Output logic: combinational read path and status
    // ------------------------------------------------------------------------
    always_comb begin
        bus.data_o = '0;
        if (state_q == RUN && bus.ce && !bus.we && in_range) begin
            bus.data_o = mem[word_idx];
        end
        ready    = (state_q == RUN);
        oor_err  = oor_err_q;
        sel_err  = sel_err_q;
        wr_count = wr_count_q;
    end

endmodule

// File: tb/tb_data_ram_resp.sv
// ----------------------------------------------------------------------------
// tb_data_ram_resp
// Drives data_ram_resp (DEPTH_LOG2 = 4) through the clear sweep, directed
// byte-lane / range / select cases, a randomized traffic phase and a reset in
// the middle of operation. Expected values come from a word-array model that
// applies the access rules directly.
// ----------------------------------------------------------------------------
module tb_data_ram_resp;

    localparam int DL2   = 4;
    localparam int WORDS = 1 << DL2;

    logic        clk;
    logic        rst;
    logic        ready;
    logic        oor_err;
    logic        sel_err;
    logic [15:0] wr_count;

    data_ram_resp_if bus ();

    data_ram_resp #(.DEPTH_LOG2(DL2)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .ready    (ready),
        .oor_err  (oor_err),
        .sel_err  (sel_err),
        .wr_count (wr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model
    logic [31:0] m_mem [WORDS];
    logic        m_ready;
    int          m_edges;
    logic        m_oor;
    logic        m_sel;
    int          m_cnt;

    int          tests_run = 0;
    int          tests_failed = 0;
    logic [31:0] last_rd;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic in_rng(input logic [31:0] a);
        return (a >> (DL2 + 2)) == 0;
    endfunction

    function automatic logic [31:0] model_read(input logic ce_v, input logic we_v,
                                               input logic [31:0] a);
        logic [31:0] w;
        w = a >> 2;
        if (m_ready && ce_v && !we_v && in_rng(a)) return m_mem[w[DL2-1:0]];
        return 32'h0;
    endfunction

    task automatic model_reset();
        m_ready = 1'b0;
        m_edges = 0;
        m_oor   = 1'b0;
        m_sel   = 1'b0;
        m_cnt   = 0;
    endtask

    // Apply one clock edge's worth of effects to the model.
    task automatic model_edge(input logic ce_v, input logic we_v, input logic [3:0] sel_v,
                              input logic [31:0] a, input logic [31:0] d);
        logic [31:0] w;
        if (!m_ready) begin
            m_edges++;
            if (m_edges == WORDS) begin
                m_ready = 1'b1;
                for (int i = 0; i < WORDS; i++) m_mem[i] = 32'h0;
            end
        end else if (ce_v) begin
            if (!in_rng(a)) m_oor = 1'b1;
            if (we_v) begin
                if (sel_v == 4'b0000) begin
                    m_sel = 1'b1;
                end else if (in_rng(a)) begin
                    w = a >> 2;
                    for (int i = 0; i < 4; i++)
                        if (sel_v[i]) m_mem[w[DL2-1:0]][8*i +: 8] = d[8*i +: 8];
                    if (m_cnt < 16'hFFFF) m_cnt++;
                end
            end
        end
    endtask

    task automatic check_status(input string tag);
        check({tag, ".ready"},    {31'b0, ready},   {31'b0, m_ready});
        check({tag, ".oor_err"},  {31'b0, oor_err}, {31'b0, m_oor});
        check({tag, ".sel_err"},  {31'b0, sel_err}, {31'b0, m_sel});
        check({tag, ".wr_count"}, {16'b0, wr_count}, 32'(m_cnt));
    endtask

    // One bus cycle: drive, check combinational read, take the edge, check state.
    task automatic access(input string tag, input logic ce_v, input logic we_v,
                          input logic [3:0] sel_v, input logic [31:0] a, input logic [31:0] d);
        bus.ce     = ce_v;
        bus.we     = we_v;
        bus.sel    = sel_v;
        bus.addr   = a;
        bus.data_i = d;
        #1;
        last_rd = bus.data_o;
        check({tag, ".data_o"}, bus.data_o, model_read(ce_v, we_v, a));
        @(posedge clk);
        model_edge(ce_v, we_v, sel_v, a, d);
        #1;
        check_status(tag);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected $finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic        ce_r, we_r;
        logic [3:0]  sel_r;
        logic [31:0] a_r, d_r;

        // ---------------- reset state ----------------
        rst = 1'b0;
        bus.ce = 1'b1; bus.we = 1'b0; bus.sel = 4'hF; bus.addr = 32'h0; bus.data_i = 32'h0;
        model_reset();
        repeat (3) @(negedge clk);
        check("rst.data_o", bus.data_o, 32'h0);
        check_status("rst");
        rst = 1'b1;

        // ---------------- clear sweep, writes ignored during INIT ----------------
        for (int e = 1; e <= WORDS; e++) begin
            access("init_wr", 1'b1, 1'b1, 4'hF, 32'h4, 32'hDEADBEEF);
        end
        check("sweep.ready_after_16", {31'b0, ready}, 32'h1);
        for (int i = 0; i < WORDS; i++) begin
            access("sweep_rd", 1'b1, 1'b0, 4'hF, 32'(i * 4), 32'h0);
        end

        // ---------------- byte-lane write ----------------
        access("bl_wr1", 1'b1, 1'b1, 4'b1111, 32'h8, 32'hFFFFFFFF);
        access("bl_wr2", 1'b1, 1'b1, 4'b0101, 32'h8, 32'h12345678);
        access("bl_rd",  1'b1, 1'b0, 4'b0000, 32'h8, 32'h0);
        check("bl_rd.const", last_rd, 32'hFF34FF78);
        check("bl.wr_count_const", {16'b0, wr_count}, 32'd2);

        // ---------------- visible in RUN, ce=0 gives 0 ----------------
        access("run_wr", 1'b1, 1'b1, 4'hF, 32'h4, 32'hDEADBEEF);
        access("run_rd", 1'b1, 1'b0, 4'hF, 32'h4, 32'h0);
        check("run_rd.const", last_rd, 32'hDEADBEEF);
        access("ce0_rd", 1'b0, 1'b0, 4'hF, 32'h4, 32'h0);
        access("we1_rd", 1'b1, 1'b1, 4'hF, 32'h7, 32'h0); // sel given, writes 0 to word 1
        access("lo_rd",  1'b1, 1'b0, 4'hF, 32'h7, 32'h0);

        // ---------------- out of range ----------------
        access("oor_wr",  1'b1, 1'b1, 4'hF, 32'h40, 32'hA5A5A5A5);
        check("oor.flag_const", {31'b0, oor_err}, 32'h1);
        access("oor_rd0", 1'b1, 1'b0, 4'hF, 32'h0, 32'h0);
        access("oor_rd",  1'b1, 1'b0, 4'hF, 32'h40, 32'h0);
        access("oor_hi",  1'b1, 1'b0, 4'hF, 32'h8000_0008, 32'h0);

        // ---------------- empty-select write ----------------
        access("sel0_wr", 1'b1, 1'b1, 4'b0000, 32'h0, 32'hFFFFFFFF);
        check("sel0.flag_const", {31'b0, sel_err}, 32'h1);
        access("sel0_rd", 1'b1, 1'b0, 4'hF, 32'h0, 32'h0);
        access("flags_hold_wr", 1'b1, 1'b1, 4'b1000, 32'h3C, 32'hC0000000);
        access("flags_hold_rd", 1'b1, 1'b0, 4'h0, 32'h3C, 32'h0);

        // ---------------- randomized traffic ----------------
        for (int n = 0; n < 400; n++) begin
            ce_r  = ($urandom_range(0, 4) != 0);
            we_r  = $urandom_range(0, 1) != 0;
            sel_r = 4'($urandom);
            d_r   = $urandom;
            if ($urandom_range(0, 9) == 0) a_r = $urandom | 32'h0000_0040;
            else a_r = 32'($urandom_range(0, WORDS - 1) * 4 + $urandom_range(0, 3));
            access("rand", ce_r, we_r, sel_r, a_r, d_r);
        end

        // ---------------- reset mid-operation ----------------
        access("mid_wr", 1'b1, 1'b1, 4'hF, 32'hC, 32'h11111111);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        #1;
        check_status("mid_rst");
        check("mid_rst.data_o", bus.data_o, 32'h0);
        #1;
        rst = 1'b1;
        for (int e = 1; e <= WORDS; e++) begin
            access("resweep", 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        end
        access("mid_rd", 1'b1, 1'b0, 4'hF, 32'hC, 32'h0);
        check("mid_rd.const", last_rd, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
